gcd_ctrl: RTL and testbench
===========================

# gcd_ctrl

Sequencing controller for the 4-bit subtractive GCD datapath (`gcd_datapath`). It accepts a start request and steers the datapath mux selects and load enables from the datapath's `ltflag`/`eqflag` feedback. It signals completion, reports the subtraction count, and flags runaway operand pairs (a zero operand) through an iteration-limit timeout. It sits beside `gcd_datapath` inside `gcd_top`.

## Interface
Parameters:
- `MAX_ITER`, default 15: maximum subtraction steps before timeout. 15 covers every legal nonzero 4-bit pair; the worst case, gcd(15,1), takes 14 steps.
- `CW`, default $clog2(MAX_ITER+1): width of the step counter.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request; sampled only in IDLE.
- `ltflag` input 1: datapath xreg < yreg (combinational from the registers).
- `eqflag` input 1: datapath xreg == yreg.
- `xsel` output 1: 1 selects `xin`, 0 selects x−y.
- `ysel` output 1: 1 selects `yin`, 0 selects y−x.
- `xld` output 1: load xreg.
- `yld` output 1: load yreg.
- `gld` output 1: load gcdreg from xreg.
- `busy` output 1: high in any state except IDLE.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; 1 means a timeout occurred and the `gcdreg` value is not meaningful.
- `steps` output CW: subtraction count of the last operation; held until the next start.

## Operation
States are IDLE, LOAD, TEST and DONE.

- **IDLE**
  - `busy`=0. All steering outputs are 0.
  - `start`=1 → LOAD. The step counter clears to 0 and the `err` flag clears.
- **LOAD**
  - Drives `xsel`=`ysel`=`xld`=`yld`=1, so the datapath captures `xin`/`yin` at the next edge.
  - → TEST unconditionally.
- **TEST** (Mealy outputs, decided in this priority order):
  - `eqflag`=1: `gld`=1 → DONE.
  - else `steps`==MAX_ITER: set the `err` flag → DONE. `gld`=0, so `gcdreg` keeps its old value.
  - else `ltflag`=1: `ysel`=0, `yld`=1 (y ← y−x), `steps`+1, stay in TEST.
  - else: `xsel`=0, `xld`=1 (x ← x−y), `steps`+1, stay in TEST.
- **DONE**
  - `done`=1 for exactly one cycle; `err` is presented alongside it.
  - → IDLE.

Rules that apply in every state:
- `start` asserted outside IDLE is ignored. There is no queueing.
- The step counter saturates at MAX_ITER and never wraps.
- Steering outputs are 0 in every state/condition not listed above. xld and yld are never both high in TEST.

## Timing
- Reset: the next edge forces IDLE. `busy`, `done`, `err`, `xsel`, `ysel`, `xld`, `yld` and `gld` all read 0, and `steps` is 0.
  - Reset mid-operation aborts immediately with no `done` pulse.
  - Datapath registers are reset only by the datapath's own reset (`gcd_top` drives it from `rst`).
- Latency, with `start` sampled at edge E0 and k subtraction steps:
  - LOAD runs in the cycle after E0.
  - xreg/yreg are valid after E1.
  - The subtractions occur at E2…E(k+1).
  - `gld` is high in the cycle before E(k+2).
  - `done` is high in the cycle after E(k+2), i.e. 3+k cycles after E0.
  - `gcdreg` is valid in the same cycle as `done`.
- Timeout: `done`/`err` rise 3+MAX_ITER cycles after E0.
- Back-to-back: `start` held high re-launches in the cycle after the DONE cycle (IDLE lasts 1 cycle minimum).
- Flags come from registers only, so there is no combinational loop through the datapath.

## Structure
- Shared package `gcd_pkg` holds:
  - the state enum (IDLE, LOAD, TEST, DONE), 2-bit encoding;
  - constant `GCD_W` = 4;
  - default `MAX_ITER`.
- `gcd_ctrl` is a single module: a state register, step counter and err flag, plus one combinational output/next-state block.
- `gcd_top` instantiates `gcd_ctrl` and `gcd_datapath`, and passes `xin`/`yin` straight through to the datapath.

## Test plan
- Operands (12,8), `start` pulse → x←4 then y←4; `steps`=2, `done` 5 cycles after start, `gcdreg`=4, `err`=0.
- Operands (15,1) → 14 steps, `gcdreg`=1, `err`=0, no timeout at the 14-step boundary.
- Operands (0,5) → `err`=1 after 15 steps, `done` at cycle 18, `gld` never asserted, `gcdreg` keeps its old value.
- Operands (7,7) and (0,0) → `steps`=0, `done` at cycle 3, `gcdreg`=7 and 0 respectively, `err`=0.
- `start` toggled while `busy` during (9,6) → ignored; a single `done` with `gcdreg`=3.
- `rst` asserted mid-TEST during (15,1) → all outputs 0 the next cycle, no `done`; a fresh start with (6,4) then yields `gcdreg`=2.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared types and constants for the subtractive GCD block:
//   gcd_state_e      controller state encoding (2 bits)
//   GCD_W            operand / result width of the datapath
//   GCD_MAX_ITER     default subtraction-step limit before timeout
package gcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_TEST = 2'd2,
        S_DONE = 2'd3
    } gcd_state_e;

    localparam int GCD_W = 4;

    // 15 covers every nonzero 4-bit pair; gcd(15,1) is the worst case at 14 steps.
    localparam int GCD_MAX_ITER = 15;

endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath
// Operand registers, subtractors and result register for subtractive GCD.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   xin, yin          operand inputs
//   xsel, ysel        1 = load operand input, 0 = load difference
//   xld, yld, gld     load enables for xreg, yreg, gcdreg (gcdreg <- xreg)
//   gcdreg            result register
//   ltflag, eqflag    xreg < yreg, xreg == yreg (from registers only)
module gcd_datapath
    import gcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [GCD_W-1:0] xin,
    input  logic [GCD_W-1:0] yin,
    input  logic             xsel,
    input  logic             ysel,
    input  logic             xld,
    input  logic             yld,
    input  logic             gld,
    output logic [GCD_W-1:0] gcdreg,
    output logic             ltflag,
    output logic             eqflag
);

    logic [GCD_W-1:0] x_q, y_q, g_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            g_q <= '0;
        end else begin
            if (xld) x_q <= xsel ? xin : (x_q - y_q);
            if (yld) y_q <= ysel ? yin : (y_q - x_q);
            if (gld) g_q <= x_q;
        end
    end

    assign ltflag = (x_q < y_q);
    assign eqflag = (x_q == y_q);
    assign gcdreg = g_q;

endmodule

// File: rtl/gcd_top.sv
// gcd_top
// Controller plus datapath for the 4-bit subtractive GCD engine.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (both halves)
//   start             launch request
//   xin, yin          operands, passed straight to the datapath
//   gcdreg            result, valid with done when err is 0
//   busy, done, err   controller status
//   steps             subtraction count of the last operation
module gcd_top
    import gcd_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [GCD_W-1:0]                     xin,
    input  logic [GCD_W-1:0]                     yin,
    output logic [GCD_W-1:0]                     gcdreg,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic [$clog2(GCD_MAX_ITER+1)-1:0]    steps
);

    logic xsel, ysel, xld, yld, gld, ltflag, eqflag;

    gcd_ctrl u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ltflag (ltflag),
        .eqflag (eqflag),
        .xsel   (xsel),
        .ysel   (ysel),
        .xld    (xld),
        .yld    (yld),
        .gld    (gld),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .steps  (steps)
    );

    gcd_datapath u_dp (
        .clk    (clk),
        .rst    (rst),
        .xin    (xin),
        .yin    (yin),
        .xsel   (xsel),
        .ysel   (ysel),
        .xld    (xld),
        .yld    (yld),
        .gld    (gld),
        .gcdreg (gcdreg),
        .ltflag (ltflag),
        .eqflag (eqflag)
    );

endmodule

// File: rtl/gcd_ctrl.sv
// gcd_ctrl
// Sequencer for the subtractive GCD datapath. Loads the operands, steers
// the subtract-and-load selects from the datapath comparison flags, loads
// the result register on equality and aborts with err when the step limit
// is reached (a zero operand never converges).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             launch request, sampled only in IDLE
//   ltflag, eqflag    datapath xreg < yreg, xreg == yreg
//   xsel, ysel        1 = load operand input, 0 = load difference
//   xld, yld, gld     load enables for xreg, yreg, gcdreg
//   busy              high in every state except IDLE
//   done              one-cycle completion pulse
//   err               timeout indication, valid with done
//   steps             subtraction count of the last operation
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start
// LOAD   | datapath captures xin/yin at the next edge
// TEST   | compare and subtract one step per cycle, or finish
// DONE   | done pulse with err alongside, then back to IDLE
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = GCD_MAX_ITER,
    parameter int CW       = $clog2(MAX_ITER + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ltflag,
    input  logic          eqflag,
    output logic          xsel,
    output logic          ysel,
    output logic          xld,
    output logic          yld,
    output logic          gld,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] steps
);

    localparam logic [CW-1:0] STEP_MAX = CW'(MAX_ITER);

    gcd_state_e    state_q, state_d;
    logic [CW-1:0] steps_q, steps_d;
    logic          err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            steps_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        err_d   = err_q;
        xsel    = 1'b0;
        ysel    = 1'b0;
        xld     = 1'b0;
        yld     = 1'b0;
        gld     = 1'b0;
        done    = 1'b0;
        err     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    steps_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                xsel    = 1'b1;
                ysel    = 1'b1;
                xld     = 1'b1;
                yld     = 1'b1;
                state_d = S_TEST;
            end
            S_TEST: begin
                if (eqflag) begin
                    gld     = 1'b1;
                    state_d = S_DONE;
                end else if (steps_q == STEP_MAX) begin
                    // Limit reached: leave gcdreg untouched and flag it.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    // Counter cannot pass STEP_MAX: the branch above catches it first.
                    steps_d = steps_q + CW'(1);
                    if (ltflag) begin
                        yld = 1'b1;
                    end else begin
                        xld = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign steps = steps_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl
// Drives gcd_ctrl against a small register model of the datapath and
// compares completion timing, step count, err and result against a
// reference GCD computed with plain arithmetic.
module tb_gcd_ctrl;
    import gcd_pkg::*;

    localparam int MI  = 15;
    localparam int CWB = $clog2(MI + 1);

    logic           clk = 1'b0;
    logic           rst, start, ltflag, eqflag;
    logic           xsel, ysel, xld, yld, gld, busy, done, err;
    logic [CWB-1:0] steps;
    logic [3:0]     xin, yin, dx, dy, dg;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    gcd_ctrl #(.MAX_ITER(MI)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ltflag (ltflag),
        .eqflag (eqflag),
        .xsel   (xsel),
        .ysel   (ysel),
        .xld    (xld),
        .yld    (yld),
        .gld    (gld),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .steps  (steps)
    );

    // Environment: behavioural datapath registers responding to the steering outputs.
    always @(posedge clk) begin
        if (rst) begin
            dx <= 4'd0; dy <= 4'd0; dg <= 4'd0;
        end else begin
            if (xld) dx <= xsel ? xin : (dx - dy);
            if (yld) dy <= ysel ? yin : (dy - dx);
            if (gld) dg <= dx;
        end
    end
    assign ltflag = (dx < dy);
    assign eqflag = (dx == dy);

    // Reference: subtractive GCD with a step limit.
    function automatic void ref_op(input int a, input int b, output int st, output bit er, output int g);
        int x = a;
        int y = b;
        st = 0;
        while (x != y && st < MI) begin
            if (x < y) y = y - x;
            else       x = x - y;
            st++;
        end
        er = (x != y);
        g  = x;
    endfunction

    // Launch one operation and observe it; cyc = 0 means no done within budget.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit toggle,
                          output int cyc, output int st, output bit er, output logic [3:0] g,
                          output bit gld_seen, output bit bad, output int extra_done);
        xin = a; yin = b;
        cyc = 0; st = 0; er = 1'b0; g = 4'd0;
        gld_seen = 1'b0; bad = 1'b0; extra_done = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (gld) gld_seen = 1'b1;
            if (xld && yld && !(xsel && ysel)) bad = 1'b1;
            if (!done && (err || !busy)) bad = 1'b1;
            if (done) begin
                cyc = c; st = int'(steps); er = err; g = dg;
                start = 1'b0;
                break;
            end
            start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) extra_done++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; xin = 4'd3; yin = 4'd5;
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, done, err, xsel, ysel, xld, yld, gld} !== 8'b0)
            $display("FAIL reset_outputs: got %b want 00000000", {busy, done, err, xsel, ysel, xld, yld, gld});
        else n_pass++;
        n_total++;
        if (steps !== '0) $display("FAIL reset_steps: got %0d want 0", steps);
        else n_pass++;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [3:0] ta [5] = '{4'd12, 4'd15, 4'd0, 4'd7, 4'd0};
        logic [3:0] tb [5] = '{4'd8,  4'd1,  4'd5, 4'd7, 4'd0};
        int cyc, st, est, eg, xd;
        bit er, eer, gs, bad;
        logic [3:0] g, gprev;
        for (int i = 0; i < 5; i++) begin
            gprev = dg;
            ref_op(int'(ta[i]), int'(tb[i]), est, eer, eg);
            run_op(ta[i], tb[i], 1'b0, cyc, st, er, g, gs, bad, xd);
            n_total++;
            if (cyc !== est + 3) $display("FAIL dir%0d_latency: got %0d want %0d", i, cyc, est + 3);
            else n_pass++;
            n_total++;
            if (st !== est) $display("FAIL dir%0d_steps: got %0d want %0d", i, st, est);
            else n_pass++;
            n_total++;
            if (er !== eer) $display("FAIL dir%0d_err: got %b want %b", i, er, eer);
            else n_pass++;
            n_total++;
            if (g !== (eer ? gprev : 4'(eg))) $display("FAIL dir%0d_gcd: got %0d want %0d", i, g, eer ? gprev : 4'(eg));
            else n_pass++;
            n_total++;
            if (gs !== !eer) $display("FAIL dir%0d_gld_seen: got %b want %b", i, gs, !eer);
            else n_pass++;
            n_total++;
            if (bad || xd != 0) $display("FAIL dir%0d_protocol: bad=%b extra_done=%0d want 0/0", i, bad, xd);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        int cyc, st, xd;
        bit er, gs, bad;
        logic [3:0] g;
        run_op(4'd9, 4'd6, 1'b1, cyc, st, er, g, gs, bad, xd);
        n_total++;
        if (cyc !== 5) $display("FAIL busy_start_latency: got %0d want 5", cyc);
        else n_pass++;
        n_total++;
        if (g !== 4'd3 || st !== 2) $display("FAIL busy_start_result: got gcd=%0d steps=%0d want 3/2", g, st);
        else n_pass++;
        n_total++;
        if (xd !== 0 || bad) $display("FAIL busy_start_single_done: extra_done=%0d bad=%b want 0/0", xd, bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc, st, xd, dcount;
        bit er, gs, bad;
        logic [3:0] g;
        xin = 4'd15; yin = 4'd1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy, done, err, xsel, ysel, xld, yld, gld} !== 8'b0 || steps !== '0)
            $display("FAIL midrst_outputs: got %b steps=%0d want 00000000 steps=0",
                     {busy, done, err, xsel, ysel, xld, yld, gld}, steps);
        else n_pass++;
        rst = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcount++;
        end
        n_total++;
        if (dcount !== 0) $display("FAIL midrst_no_done: got %0d done pulses want 0", dcount);
        else n_pass++;
        run_op(4'd6, 4'd4, 1'b0, cyc, st, er, g, gs, bad, xd);
        n_total++;
        if (g !== 4'd2 || st !== 2 || cyc !== 5 || er !== 1'b0)
            $display("FAIL midrst_restart: got gcd=%0d steps=%0d cyc=%0d err=%b want 2/2/5/0", g, st, cyc, er);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dq[$];
        xin = 4'd12; yin = 4'd8;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) dq.push_back(c);
            if (dq.size() == 2) break;
        end
        start = 1'b0;
        n_total++;
        if (dq.size() != 2) $display("FAIL b2b_two_dones: got %0d want 2", dq.size());
        else n_pass++;
        if (dq.size() == 2) begin
            n_total++;
            if (dq[0] !== 5 || dq[1] !== 11)
                $display("FAIL b2b_timing: got %0d,%0d want 5,11", dq[0], dq[1]);
            else n_pass++;
        end
        repeat (5) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || steps !== CWB'(2))
            $display("FAIL b2b_steps_held: got busy=%b steps=%0d want 0/2", busy, steps);
        else n_pass++;
    endtask

    task automatic test_random();
        int cyc, st, est, eg, xd;
        bit er, eer, gs, bad;
        logic [3:0] g, gprev, a, b;
        for (int i = 0; i < 25; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            gprev = dg;
            ref_op(int'(a), int'(b), est, eer, eg);
            run_op(a, b, 1'b0, cyc, st, er, g, gs, bad, xd);
            n_total++;
            if (cyc !== est + 3 || st !== est || er !== eer ||
                g !== (eer ? gprev : 4'(eg)) || bad || xd != 0)
                $display("FAIL rand(%0d,%0d): got cyc=%0d steps=%0d err=%b gcd=%0d want cyc=%0d steps=%0d err=%b gcd=%0d",
                         a, b, cyc, st, er, g, est + 3, est, eer, eer ? gprev : 4'(eg));
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; xin = 4'd0; yin = 4'd0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
